// File: rtl/cu_stack_pkg.sv
// Shared types for the cu_stack control unit: opcode and state encodings plus
// the opcode field locator used by the decoder.
package cu_stack_pkg;

  typedef enum logic [2:0] {
    OP_MOVE    = 3'b000,
    OP_IMM     = 3'b001,
    OP_JUMP    = 3'b010,
    OP_BRANCH  = 3'b011,
    OP_CALL    = 3'b100,
    OP_RETURN  = 3'b101,
    OP_HALT    = 3'b110,
    OP_ILLEGAL = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_COND  = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  localparam int unsigned OpcodeW = 3;

  // Opcode occupies the top three bits of the instruction word.
  function automatic int unsigned opcode_lsb(input int unsigned data_width);
    return data_width - OpcodeW;
  endfunction

endpackage

// File: rtl/cu_stack_ras.sv
// Return-address stack for cu_stack. Level, full, empty and top-of-stack are
// all registered; callers never push and pop in the same cycle.
module cu_stack_ras
  import cu_stack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic [ADDR_WIDTH-1:0]            push_addr_i,
  output logic [ADDR_WIDTH-1:0]            top_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [$clog2(DEPTH+1)-1:0]       level_o
);

  localparam int unsigned LevelW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned Slots  = 1 << IdxW;

  logic [ADDR_WIDTH-1:0] mem_q [Slots];
  logic [ADDR_WIDTH-1:0] top_q;
  logic [LevelW-1:0]     level_q, level_d;
  logic                  full_q, empty_q;
  logic                  push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin : level_next
    level_d = level_q;
    if (push_ok) begin
      level_d = level_q + LevelW'(1);
    end else if (pop_ok) begin
      level_d = level_q - LevelW'(1);
    end
  end

  // Top is tracked separately so the caller sees a registered return address.
  always_ff @(posedge clk_i or posedge rst_i) begin : stack_regs
    if (rst_i) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      top_q   <= '0;
      for (int i = 0; i < int'(Slots); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == LevelW'(DEPTH));
      empty_q <= (level_d == '0);
      if (push_ok) begin
        mem_q[IdxW'(level_q)] <= push_addr_i;
        top_q                 <= push_addr_i;
      end else if (pop_ok) begin
        top_q <= (level_q >= LevelW'(2)) ? mem_q[IdxW'(level_q - LevelW'(2))] : '0;
      end
    end
  end

  assign top_o   = top_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/cu_stack.sv
// cu_stack control unit: fetch/decode loop with return-address stack, MIB issue
// and branch-condition handshake. Optional CU_STACK_PERF_COUNTERS_EN adds counters.
module cu_stack
  import cu_stack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  input  logic [ADDR_WIDTH-1:0]              start_addr_i,
  output logic                               done_o,
  output logic                               idle_o,
  output logic                               error_o,
  output logic [ADDR_WIDTH-1:0]              pc_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level_o,
  output logic                               instr_req_valid_o,
  output logic [ADDR_WIDTH-1:0]              instr_req_addr_o,
  input  logic                               instr_req_ready_i,
  input  logic                               instr_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]              instr_rsp_data_i,
  input  logic                               cond_valid_i,
  input  logic [DATA_WIDTH-1:0]              cond_data_i,
  output logic                               cond_ready_o,
  output logic                               mib_move_valid_o,
  output logic                               mib_immediate_valid_o,
  output logic [DATA_WIDTH-4:0]              mib_operand_o,
  input  logic                               mib_ready_i
`ifdef CU_STACK_PERF_COUNTERS_EN
  ,
  output logic [31:0]                        cycle_count_o,
  output logic [31:0]                        issued_count_o
`endif
);

  localparam int unsigned OpLsb    = opcode_lsb(DATA_WIDTH);
  localparam int unsigned OperandW = DATA_WIDTH - OpcodeW;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;
  logic                  idle_q, idle_d;
  logic                  req_valid_q, req_valid_d;
  logic                  move_valid_q, move_valid_d;
  logic                  imm_valid_q, imm_valid_d;
  logic                  cond_ready_q, cond_ready_d;

  opcode_e               rsp_op, next_op;
  logic [ADDR_WIDTH-1:0] rsp_target, instr_target;

  logic                  ras_push, ras_pop, ras_full, ras_empty;
  logic [ADDR_WIDTH-1:0] ras_top;

  assign rsp_op       = opcode_e'(instr_rsp_data_i[OpLsb +: OpcodeW]);
  assign rsp_target   = instr_rsp_data_i[ADDR_WIDTH-1:0];
  assign instr_target = instr_q[ADDR_WIDTH-1:0];
  assign pc_inc       = pc_q + ADDR_WIDTH'(1);

  cu_stack_ras #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (STACK_DEPTH)
  ) u_ras (
    .clk_i       (clock_i),
    .rst_i       (reset_i),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_addr_i (pc_inc),
    .top_o       (ras_top),
    .full_o      (ras_full),
    .empty_o     (ras_empty),
    .level_o     (stack_level_o)
  );

  // Next state plus registered-output targets, all derived from state_d.
  always_comb begin : fsm_next
    state_d  = state_q;
    pc_d     = pc_q;
    error_d  = error_q;
    instr_d  = instr_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pc_d    = start_addr_i;
          error_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (instr_req_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (instr_rsp_valid_i) begin
          instr_d = instr_rsp_data_i;
          case (rsp_op)
            OP_MOVE, OP_IMM: state_d = ST_ISSUE;
            OP_JUMP: begin
              if (rsp_target == pc_q) begin
                state_d = ST_HALT;
              end else begin
                pc_d    = rsp_target;
                state_d = ST_FETCH;
              end
            end
            OP_BRANCH: state_d = ST_COND;
            OP_CALL: begin
              if (ras_full) begin
                error_d = 1'b1;
                state_d = ST_HALT;
              end else begin
                ras_push = 1'b1;
                pc_d     = rsp_target;
                state_d  = ST_FETCH;
              end
            end
            OP_RETURN: begin
              if (ras_empty) begin
                error_d = 1'b1;
                state_d = ST_HALT;
              end else begin
                ras_pop = 1'b1;
                pc_d    = ras_top;
                state_d = ST_FETCH;
              end
            end
            OP_HALT: state_d = ST_HALT;
            default: begin
              error_d = 1'b1;
              state_d = ST_HALT;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        if (mib_ready_i) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      ST_COND: begin
        if (cond_valid_i) begin
          pc_d    = (|cond_data_i) ? instr_target : pc_inc;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    next_op      = opcode_e'(instr_d[OpLsb +: OpcodeW]);
    idle_d       = (state_d == ST_IDLE);
    done_d       = (state_d == ST_HALT);
    req_valid_d  = (state_d == ST_FETCH);
    cond_ready_d = (state_d == ST_COND);
    move_valid_d = (state_d == ST_ISSUE) && (next_op == OP_MOVE);
    imm_valid_d  = (state_d == ST_ISSUE) && (next_op == OP_IMM);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin : fsm_regs
    if (reset_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      idle_q       <= 1'b1;
      req_valid_q  <= 1'b0;
      move_valid_q <= 1'b0;
      imm_valid_q  <= 1'b0;
      cond_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      error_q      <= error_d;
      done_q       <= done_d;
      idle_q       <= idle_d;
      req_valid_q  <= req_valid_d;
      move_valid_q <= move_valid_d;
      imm_valid_q  <= imm_valid_d;
      cond_ready_q <= cond_ready_d;
    end
  end

  assign done_o                = done_q;
  assign idle_o                = idle_q;
  assign error_o               = error_q;
  assign pc_o                  = pc_q;
  assign instr_req_valid_o     = req_valid_q;
  assign instr_req_addr_o      = pc_q;
  assign cond_ready_o          = cond_ready_q;
  assign mib_move_valid_o      = move_valid_q;
  assign mib_immediate_valid_o = imm_valid_q;
  assign mib_operand_o         = instr_q[OperandW-1:0];

`ifdef CU_STACK_PERF_COUNTERS_EN
  logic [31:0] cycle_q, issued_q;
  logic        start_ok, mib_hs;

  assign start_ok = (state_q == ST_IDLE) && start_i;
  assign mib_hs   = (move_valid_q || imm_valid_q) && mib_ready_i;

  // Saturating activity counters, restarted with each accepted program.
  always_ff @(posedge clock_i or posedge reset_i) begin : perf_regs
    if (reset_i) begin
      cycle_q  <= '0;
      issued_q <= '0;
    end else if (start_ok) begin
      cycle_q  <= '0;
      issued_q <= '0;
    end else begin
      if ((state_q != ST_IDLE) && (cycle_q != '1)) cycle_q <= cycle_q + 32'd1;
      if (mib_hs && (issued_q != '1)) issued_q <= issued_q + 32'd1;
    end
  end

  assign cycle_count_o  = cycle_q;
  assign issued_count_o = issued_q;
`endif

endmodule

// File: tb/tb_cu_stack.sv
// Scoreboard bench for cu_stack: directed programs in a behavioural instruction
// memory; a monitor checks every fetch address and MIB transfer against queues.
module tb_cu_stack;

  localparam logic [2:0] OP_MOV = 3'b000, OP_IMM = 3'b001, OP_JMP = 3'b010, OP_BR = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100, OP_RET = 3'b101, OP_HLT = 3'b110, OP_ILL = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr;
  logic        done, idle, error;
  logic [7:0]  pc;
  logic [2:0]  stack_level;
  logic        req_valid, req_ready;
  logic [7:0]  req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        cond_valid, cond_ready;
  logic [31:0] cond_data;
  logic        move_valid, imm_valid, mib_ready;
  logic [28:0] mib_operand;

  logic [31:0] mem [256];
  logic [7:0]  exp_fetch [$];
  logic [29:0] exp_mib [$];
  int          checks = 0;
  int          failures = 0;
  int          rsp_delay = 1;
  int          cond_cnt = 0;
  int          done_cnt = 0;
  int          max_level = 0;
  logic        bp_en = 1'b0;

  always #5 clk = ~clk;

  cu_stack #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .STACK_DEPTH(4)) dut (
    .clock_i               (clk),
    .reset_i               (rst),
    .start_i               (start),
    .start_addr_i          (start_addr),
    .done_o                (done),
    .idle_o                (idle),
    .error_o               (error),
    .pc_o                  (pc),
    .stack_level_o         (stack_level),
    .instr_req_valid_o     (req_valid),
    .instr_req_addr_o      (req_addr),
    .instr_req_ready_i     (req_ready),
    .instr_rsp_valid_i     (rsp_valid),
    .instr_rsp_data_i      (rsp_data),
    .cond_valid_i          (cond_valid),
    .cond_data_i           (cond_data),
    .cond_ready_o          (cond_ready),
    .mib_move_valid_o      (move_valid),
    .mib_immediate_valid_o (imm_valid),
    .mib_operand_o         (mib_operand),
    .mib_ready_i           (mib_ready)
  );

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [7:0] tgt);
    return {op, 21'd0, tgt};
  endfunction

  function automatic logic [31:0] enc_op(input logic [2:0] op, input logic [28:0] operand);
    return {op, operand};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction memory: response rsp_delay cycles after each accepted request.
  initial begin : mem_model
    logic       hs;
    logic [7:0] a, pend;
    int         cnt;
    cnt = 0; pend = '0; rsp_valid = 1'b0; rsp_data = '0;
    forever begin
      @(posedge clk);
      hs = req_valid && req_ready;
      a  = req_addr;
      #1;
      rsp_valid = 1'b0;
      if (hs) begin
        pend = a;
        cnt  = rsp_delay;
      end
      if (cnt == 1) begin
        rsp_valid = 1'b1;
        rsp_data  = mem[pend];
        cnt       = 0;
      end else if (cnt > 1) begin
        cnt--;
      end
    end
  end

  initial begin : mib_ready_drv
    int bp_cnt;
    bp_cnt = 0;
    mib_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bp_cnt++;
        mib_ready = ((bp_cnt % 3) == 2);
      end else begin
        mib_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every fetch and MIB handshake.
  initial begin : monitor
    logic [7:0]  ef;
    logic [29:0] em;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_valid && req_ready) begin
          if (exp_fetch.size() == 0) begin
            checks++; failures++;
            $display("FAIL fetch_unexpected: got addr 0x%0h expected none", req_addr);
          end else begin
            ef = exp_fetch.pop_front();
            chk("fetch_addr", 32'(req_addr), 32'(ef));
          end
        end
        if ((move_valid || imm_valid) && mib_ready) begin
          if (exp_mib.size() == 0) begin
            checks++; failures++;
            $display("FAIL mib_unexpected: got imm=%0d operand=0x%0h expected none", imm_valid, mib_operand);
          end else begin
            em = exp_mib.pop_front();
            chk("mib_xfer", 32'({imm_valid, mib_operand}), 32'(em));
          end
        end
        if (move_valid || imm_valid || cond_ready)
          chk("out_exclusive", 32'(int'(move_valid) + int'(imm_valid) + int'(cond_ready)), 32'd1);
        if (cond_ready && cond_valid) cond_cnt++;
        if (done) done_cnt++;
        if (int'(stack_level) > max_level) max_level = int'(stack_level);
      end
    end
  end

  task automatic do_start(input logic [7:0] sa);
    @(posedge clk); #1;
    start = 1'b1; start_addr = sa;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      cyc++;
      if (cyc > 300) begin
        checks++; failures++;
        $display("FAIL done_timeout: got no done after %0d cycles expected a pulse", cyc);
        break;
      end
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(idle), 32'd1);
  endtask

  task automatic check_drained(input string name);
    chk(name, 32'(exp_fetch.size() + exp_mib.size()), 32'd0);
    exp_fetch.delete();
    exp_mib.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin : stim
    int cyc;
    rst = 1'b1; start = 1'b0; start_addr = '0;
    req_ready = 1'b1; cond_valid = 1'b1; cond_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = enc(OP_ILL, 8'h00);

    repeat (2) @(negedge clk);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_level", 32'(stack_level), 32'd0);
    chk("rst_outs", 32'({req_valid, move_valid, imm_valid, cond_ready}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Immediate, move, halt: exact latency and ordering
    mem[8'h10] = enc_op(OP_IMM, 29'h00ABCDE);
    mem[8'h11] = enc_op(OP_MOV, 29'h1234567);
    mem[8'h12] = enc(OP_HLT, 8'h00);
    exp_fetch.push_back(8'h10); exp_fetch.push_back(8'h11); exp_fetch.push_back(8'h12);
    exp_mib.push_back({1'b1, 29'h00ABCDE}); exp_mib.push_back({1'b0, 29'h1234567});
    do_start(8'h10);
    chk("first_req_valid", 32'(req_valid), 32'd1);
    chk("first_req_addr", 32'(req_addr), 32'h10);
    chk("busy_not_idle", 32'(idle), 32'd0);
    wait_done(cyc);
    chk("prog1_latency", 32'(cyc), 32'd8);
    chk("prog1_error", 32'(error), 32'd0);
    check_drained("prog1_drained");

    // Same program with MIB backpressure
    exp_fetch.push_back(8'h10); exp_fetch.push_back(8'h11); exp_fetch.push_back(8'h12);
    exp_mib.push_back({1'b1, 29'h00ABCDE}); exp_mib.push_back({1'b0, 29'h1234567});
    bp_en = 1'b1;
    do_start(8'h10);
    wait_done(cyc);
    bp_en = 1'b0;
    chk("bp_error", 32'(error), 32'd0);
    check_drained("bp_drained");

    // Branch not taken, then taken
    mem[8'h00] = enc(OP_BR, 8'h05);
    mem[8'h01] = enc(OP_HLT, 8'h00);
    mem[8'h05] = enc(OP_HLT, 8'h00);
    cond_data = 32'd0; cond_cnt = 0;
    exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
    do_start(8'h00);
    wait_done(cyc);
    chk("br0_cond_once", 32'(cond_cnt), 32'd1);
    check_drained("br0_drained");
    cond_data = 32'd7; cond_cnt = 0;
    exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h05);
    do_start(8'h00);
    wait_done(cyc);
    chk("br7_cond_once", 32'(cond_cnt), 32'd1);
    check_drained("br7_drained");

    // Five nested calls overflow a four-entry stack
    for (int i = 0; i < 5; i++) begin
      mem[8'h20 + 8'(i)] = enc(OP_CALL, 8'h21 + 8'(i));
      exp_fetch.push_back(8'h20 + 8'(i));
    end
    max_level = 0; done_cnt = 0;
    do_start(8'h20);
    wait_done(cyc);
    chk("call_max_level", 32'(max_level), 32'd4);
    chk("call_level", 32'(stack_level), 32'd4);
    chk("call_overflow_err", 32'(error), 32'd1);
    chk("call_done_cnt", 32'(done_cnt), 32'd1);
    check_drained("call_drained");
    apply_reset();
    chk("post_rst_level", 32'(stack_level), 32'd0);

    // Call then return resumes at call site + 1
    mem[8'h30] = enc(OP_CALL, 8'h40);
    mem[8'h40] = enc(OP_RET, 8'h00);
    mem[8'h31] = enc(OP_HLT, 8'h00);
    exp_fetch.push_back(8'h30); exp_fetch.push_back(8'h40); exp_fetch.push_back(8'h31);
    do_start(8'h30);
    wait_done(cyc);
    chk("callret_error", 32'(error), 32'd0);
    chk("callret_level", 32'(stack_level), 32'd0);
    check_drained("callret_drained");

    // Return on empty stack, illegal opcode, error cleared by start
    mem[8'h50] = enc(OP_RET, 8'h00);
    exp_fetch.push_back(8'h50);
    do_start(8'h50);
    wait_done(cyc);
    chk("ret_empty_err", 32'(error), 32'd1);
    mem[8'h58] = enc(OP_ILL, 8'h00);
    exp_fetch.push_back(8'h58);
    do_start(8'h58);
    chk("start_clears_err", 32'(error), 32'd0);
    wait_done(cyc);
    chk("illegal_err", 32'(error), 32'd1);
    mem[8'h60] = enc(OP_HLT, 8'h00);
    exp_fetch.push_back(8'h60);
    do_start(8'h60);
    wait_done(cyc);
    chk("halt_no_err", 32'(error), 32'd0);
    check_drained("err_drained");

    // Jump to self terminates; plain jump; PC wrap
    mem[8'h03] = enc(OP_JMP, 8'h03);
    exp_fetch.push_back(8'h03);
    done_cnt = 0;
    do_start(8'h03);
    wait_done(cyc);
    repeat (4) @(negedge clk);
    chk("selfjmp_done_cnt", 32'(done_cnt), 32'd1);
    chk("selfjmp_err", 32'(error), 32'd0);
    check_drained("selfjmp_drained");
    mem[8'h70] = enc(OP_JMP, 8'h75);
    mem[8'h75] = enc(OP_HLT, 8'h00);
    exp_fetch.push_back(8'h70); exp_fetch.push_back(8'h75);
    do_start(8'h70);
    wait_done(cyc);
    check_drained("jmp_drained");
    mem[8'hFF] = enc_op(OP_MOV, 29'h0000055);
    mem[8'h00] = enc(OP_HLT, 8'h00);
    exp_fetch.push_back(8'hFF); exp_fetch.push_back(8'h00);
    exp_mib.push_back({1'b0, 29'h0000055});
    do_start(8'hFF);
    wait_done(cyc);
    chk("wrap_err", 32'(error), 32'd0);
    check_drained("wrap_drained");

    // Reset while waiting on memory; late response lands in IDLE
    rsp_delay = 2;
    mem[8'h80] = enc(OP_CALL, 8'h81);
    mem[8'h81] = enc_op(OP_MOV, 29'h0000077);
    exp_fetch.push_back(8'h80); exp_fetch.push_back(8'h81);
    do_start(8'h80);
    cyc = 0;
    while (!(req_valid && req_addr == 8'h81) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstwait_reached", 32'(cyc < 50), 32'd1);
    @(posedge clk); #2;
    chk("rstwait_level_pre", 32'(stack_level), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstwait_no_mib", 32'({move_valid, imm_valid}), 32'd0);
      chk("rstwait_idle", 32'(idle), 32'd1);
      chk("rstwait_level", 32'(stack_level), 32'd0);
    end
    chk("rstwait_pc", 32'(pc), 32'd0);
    check_drained("rstwait_drained");
    rsp_delay = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_stack.md
Name: cu_stack

Overview:
- Next-generation control unit for the SCAD core.
- Fetches instruction words from instruction memory and decodes them.
- Forwards move/immediate instructions to the MIB and executes jump, branch, call, return and halt itself.
- Adds a parametrised return-address stack, a programmable start address, explicit halt and error reporting.

Parameters:
- ADDR_WIDTH, 8, instruction memory address / PC width.
- DATA_WIDTH, 32, instruction word and branch-condition width.
- STACK_DEPTH, 4, return-address stack entries (>=1).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin execution at start_addr (sampled in IDLE only)
- start_addr  input  ADDR_WIDTH  first PC
- done  output  1  one-cycle pulse on normal termination
- idle  output  1  high while in IDLE
- error  output  1  sticky fault flag, cleared by next accepted start
- pc  output  ADDR_WIDTH  current PC (debug)
- stack_level  output  $clog2(STACK_DEPTH+1)  occupied stack entries
- instr_mem  mem_interface.requester  bundle  address request/ready, data response/valid
- branch_condition  data_interface.consumer  bundle  condition operand for branches
- to_mib  instruction_interface.producer  bundle  move/immediate instructions to MIB

Behaviour:
- Reset: state IDLE; pc=0, stack_level=0, error=0, done=0, idle=1; all request/valid outputs 0.
- Encoding: opcode = instr[DATA_WIDTH-1:DATA_WIDTH-3]; target = instr[ADDR_WIDTH-1:0].
  - 000 move, 001 immediate, 010 jump, 011 branch, 100 call, 101 return, 110 halt, 111 illegal.
- States: IDLE, FETCH, WAIT, ISSUE, COND, HALT.
- IDLE:
  - start=1 -> pc<=start_addr, error<=0, go to FETCH next cycle.
  - start in any other state is ignored.
- FETCH:
  - Drive request valid with addr=pc; hold stable until ready.
  - On handshake -> WAIT.
  - Exactly one outstanding request.
- WAIT:
  - On response valid, latch the word.
  - move/immediate -> ISSUE.
  - jump: target==pc -> HALT (self-loop terminates); else pc<=target -> FETCH.
  - branch -> COND.
  - call:
    - stack not full -> push pc+1, pc<=target -> FETCH.
    - stack full -> error<=1 -> HALT.
  - return:
    - stack not empty -> pop into pc -> FETCH.
    - stack empty -> error<=1 -> HALT.
  - halt -> HALT.
  - illegal -> error<=1 -> HALT.
- ISSUE:
  - Assert exactly one of to_mib.move_valid / immediate_valid with decoded fields.
  - Hold until ready; then pc<=pc+1 -> FETCH.
- COND:
  - Assert branch_condition ready.
  - On valid: consume; nonzero -> pc<=target, zero -> pc<=pc+1; -> FETCH.
- HALT: done=1 for exactly this cycle -> IDLE. done pulses on error termination too.
- Arithmetic: pc+1 wraps modulo 2^ADDR_WIDTH with no error. Pushed address also wraps.
- Output exclusivity: at most one of move_valid, immediate_valid, condition ready is asserted per cycle.
- Reset mid-operation: immediately IDLE, stack emptied. A memory response arriving in IDLE is ignored.
- Latency: start -> first request 1 cycle. Minimum per-instruction cycles:
  - move/immediate: 3 (FETCH, WAIT, ISSUE) with ready=1.
  - jump/call/return: 2.

Optional Feature:
- CU_STACK_PERF_COUNTERS_EN defined:
  - Adds outputs cycle_count and issued_count, both 32-bit.
  - cycle_count counts cycles not in IDLE; issued_count counts to_mib handshakes.
  - Both cleared on accepted start and reset; saturate at all-ones.
- Undefined: ports and logic absent.

Decomposition:
- Package cu_stack_pkg holds:
  - opcode enum;
  - state enum;
  - opcode field position function parametrised by DATA_WIDTH.
- Sub-module cu_stack_ras:
  - return-address stack with push/pop, full/empty, level;
  - push and pop never asserted in the same cycle.

Test Plan:
- start_addr=0x10, program {imm, move, halt} with all readies=1 -> two to_mib transfers in order; done pulses at cycle 8 after start; error=0.
- Branch at 0x00 target 0x05, condition 0 then rerun with 7 -> next fetch addr 0x01, then 0x05; condition consumed exactly once each run.
- Call depth: STACK_DEPTH=4, five nested calls -> stack_level reaches 4; fifth call sets error=1, done pulses, idle returns.
- Return with empty stack, and opcode 111 -> error=1, done pulse; next start clears error.
- Jump to self at 0x3 -> done pulse, no further fetch. PC at 0xFF executing move -> next fetch addr 0x00.
- Assert reset during WAIT with a response arriving 1 cycle later -> idle=1, stack_level=0, no to_mib valid, response ignored.
